// File: rtl/riscv_configs.sv
// Shared configuration for the bus arbiter slice.
// Supplies XLEN, the FSM state encodings and a counter-width helper.
package riscv_configs;

  localparam int XLEN = 32;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY
  } arb_state_t;

  // A zero timeout still needs a 1-bit counter to keep the logic legal.
  function automatic int cnt_w(input int t);
    return (t <= 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/riscv_mux.sv
// Generic N-input word multiplexer, inputs packed low index first.
// Ports: i_mux_in (N_MUX_IN*W), i_mux_sel (index), o_mux_out (W).
module riscv_mux
  import riscv_configs::*;
#(
  parameter int N_MUX_IN = 2,
  parameter int W        = XLEN,
  parameter int SW       = $clog2(N_MUX_IN)
) (
  input  logic [N_MUX_IN*W-1:0] i_mux_in,
  input  logic [SW-1:0]         i_mux_sel,
  output logic [W-1:0]          o_mux_out
);

  always_comb begin
    o_mux_out = '0;
    for (int k = 0; k < N_MUX_IN; k++) begin
      if (i_mux_sel == SW'(k)) begin
        o_mux_out = i_mux_in[W*k +: W];
      end
    end
  end

endmodule

// File: rtl/riscv_rr_arbiter.sv
// Combinational round-robin pick: first set req after last, wrapping.
// Ports: i_req, i_last (previous winner), o_winner, o_any_req.
module riscv_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  output logic [IW-1:0]    o_winner,
  output logic             o_any_req
);

  logic found;
  int   idx;

  always_comb begin
    o_winner  = '0;
    o_any_req = |i_req;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(i_last) + i) % N_REQ;
      if (!found && i_req[idx]) begin
        found    = 1'b1;
        o_winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/riscv_bus_arbiter.sv
// Round-robin arbiter sharing one bus port, one transaction in flight.
// Ports: i_clk/i_rst (sync, active-high); per-requester i_req, i_req_we,
//   i_req_concat_addr/wdata (XLEN per slot); o_gnt/o_ack/o_err per
//   requester; o_rdata; bus side o_bus_req/we/addr/wdata, i_bus_ack/rdata.
module riscv_bus_arbiter
  import riscv_configs::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ-1:0]      i_req_we,
  input  logic [N_REQ*XLEN-1:0] i_req_concat_addr,
  input  logic [N_REQ*XLEN-1:0] i_req_concat_wdata,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [N_REQ-1:0]      o_ack,
  output logic [N_REQ-1:0]      o_err,
  output logic [XLEN-1:0]       o_rdata,
  output logic                  o_bus_req,
  output logic                  o_bus_we,
  output logic [XLEN-1:0]       o_bus_addr,
  output logic [XLEN-1:0]       o_bus_wdata,
  input  logic                  i_bus_ack,
  input  logic [XLEN-1:0]       i_bus_rdata
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_w(TIMEOUT_CYCLES);

  arb_state_t state_q, state_d;

  logic [IW-1:0]    sel_q, sel_d;
  logic [IW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    win;
  logic             any_req;
  logic             busy;
  logic             expire;
  logic             done;

  riscv_rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr (
    .i_req     (i_req),
    .i_last    (last_q),
    .o_winner  (win),
    .o_any_req (any_req)
  );

  riscv_mux #(
    .N_MUX_IN (N_REQ),
    .W        (XLEN),
    .SW       (IW)
  ) u_addr_mux (
    .i_mux_in  (i_req_concat_addr),
    .i_mux_sel (sel_q),
    .o_mux_out (o_bus_addr)
  );

  riscv_mux #(
    .N_MUX_IN (N_REQ),
    .W        (XLEN),
    .SW       (IW)
  ) u_wdata_mux (
    .i_mux_in  (i_req_concat_wdata),
    .i_mux_sel (sel_q),
    .o_mux_out (o_bus_wdata)
  );

  assign busy = (state_q == S_BUSY);

  // A real ack on the expiry cycle wins, so it completes without error.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_to
      assign expire = busy & ~i_bus_ack &
                      (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_to
      assign expire = 1'b0;
    end
  endgenerate

  assign done = busy & (i_bus_ack | expire);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_BUSY;
          sel_d   = win;
          gnt_d   = N_REQ'(1) << win;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (done) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          last_d  = sel_q;
          cnt_d   = '0;
        end else if (TIMEOUT_CYCLES > 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // gnt_q is onehot(sel) whenever BUSY, so it doubles as the ack mask.
  assign o_gnt     = gnt_q;
  assign o_ack     = done ? gnt_q : '0;
  assign o_err     = expire ? gnt_q : '0;
  assign o_rdata   = i_bus_rdata;
  assign o_bus_req = busy;
  assign o_bus_we  = busy & i_req_we[sel_q];

endmodule

// File: tb/tb_riscv_bus_arbiter.sv
// Directed bench for riscv_bus_arbiter with a completion scoreboard.
// Two DUTs share stimulus: TIMEOUT_CYCLES=4 and TIMEOUT_CYCLES=0.
module tb_riscv_bus_arbiter;
  import riscv_configs::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]      req, req_we;
  logic [N*XLEN-1:0] addr_c, wdata_c;
  logic              bus_ack;
  logic [XLEN-1:0]   bus_rdata;

  logic [N-1:0]    gnt_a, ack_a, err_a;
  logic [XLEN-1:0] rdata_a, baddr_a, bwdata_a;
  logic            breq_a, bwe_a;

  logic [N-1:0]    gnt_z, ack_z, err_z;
  logic [XLEN-1:0] rdata_z, baddr_z, bwdata_z;
  logic            breq_z, bwe_z;

  riscv_bus_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (4)
  ) u_dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_req              (req),
    .i_req_we           (req_we),
    .i_req_concat_addr  (addr_c),
    .i_req_concat_wdata (wdata_c),
    .o_gnt              (gnt_a),
    .o_ack              (ack_a),
    .o_err              (err_a),
    .o_rdata            (rdata_a),
    .o_bus_req          (breq_a),
    .o_bus_we           (bwe_a),
    .o_bus_addr         (baddr_a),
    .o_bus_wdata        (bwdata_a),
    .i_bus_ack          (bus_ack),
    .i_bus_rdata        (bus_rdata)
  );

  riscv_bus_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (0)
  ) u_dut0 (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_req              (req),
    .i_req_we           (req_we),
    .i_req_concat_addr  (addr_c),
    .i_req_concat_wdata (wdata_c),
    .o_gnt              (gnt_z),
    .o_ack              (ack_z),
    .o_err              (err_z),
    .o_rdata            (rdata_z),
    .o_bus_req          (breq_z),
    .o_bus_we           (bwe_z),
    .o_bus_addr         (baddr_z),
    .o_bus_wdata        (bwdata_z),
    .i_bus_ack          (bus_ack),
    .i_bus_rdata        (bus_rdata)
  );

  typedef struct {
    logic [N-1:0]    ack;
    logic [N-1:0]    err;
    logic [XLEN-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_err++;
      $error("FAIL %s: observed=ack with empty scoreboard expected=entry",
             tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ack"}, 64'(ack_a), 64'(e.ack));
      chk({tag, "_err"}, 64'(err_a), 64'(e.err));
      if (e.err == '0) chk({tag, "_rdata"}, 64'(rdata_a), 64'(e.rdata));
    end
  endtask

  logic [N-1:0] oh;

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_we    = '0;
    addr_c    = '0;
    wdata_c   = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    tick();
    tick();
    chk("rst_gnt", 64'(gnt_a), 64'(0));
    chk("rst_breq", 64'(breq_a), 64'(0));
    chk("rst_ack", 64'(ack_a), 64'(0));
    chk("rst_err", 64'(err_a), 64'(0));
    chk("rst_gnt_z", 64'(gnt_z), 64'(0));
    rst = 1'b0;

    // single read from requester 0, acked in the 3rd BUSY cycle
    addr_c[0 +: XLEN] = 32'h0000_1000;
    req = 2'b01;
    sb.push_back('{2'b01, 2'b00, 32'hDEAD_BEEF});
    tick();
    chk("t1_gnt", 64'(gnt_a), 64'(2'b01));
    chk("t1_breq", 64'(breq_a), 64'(1));
    chk("t1_addr", 64'(baddr_a), 64'(32'h1000));
    chk("t1_we", 64'(bwe_a), 64'(0));
    chk("t1_c1_ack", 64'(ack_a), 64'(0));
    tick();
    chk("t1_c2_ack", 64'(ack_a), 64'(0));
    tick();
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    #1;
    sb_check("t1");
    tick();
    bus_ack = 1'b0;
    req     = '0;
    #1;
    chk("t1_idle_breq", 64'(breq_a), 64'(0));
    chk("t1_idle_gnt", 64'(gnt_a), 64'(0));

    // both requesting after reset: 0,1,0,1 with an IDLE gap each
    rst = 1'b1;
    tick();
    rst = 1'b0;
    addr_c[0 +: XLEN]    = 32'h0000_A000;
    addr_c[XLEN +: XLEN] = 32'h0000_B000;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      oh = 2'b01 << (i % 2);
      sb.push_back('{oh, 2'b00, 32'h100 + i});
      tick();
      chk("rr_gnt", 64'(gnt_a), 64'(oh));
      chk("rr_addr", 64'(baddr_a),
          (i % 2 == 0) ? 64'h0000_A000 : 64'h0000_B000);
      bus_ack   = 1'b1;
      bus_rdata = 32'h100 + i;
      #1;
      sb_check("rr");
      tick();
      bus_ack = 1'b0;
      #1;
      chk("rr_gap_breq", 64'(breq_a), 64'(0));
      chk("rr_gap_gnt", 64'(gnt_a), 64'(0));
    end

    // write steering from requester 1, held for three BUSY cycles
    req    = 2'b10;
    req_we = 2'b10;
    addr_c[XLEN +: XLEN]  = 32'h0000_2004;
    wdata_c[XLEN +: XLEN] = 32'h1234_5678;
    bus_rdata = '0;
    sb.push_back('{2'b10, 2'b00, 32'h0});
    tick();
    for (int c = 1; c <= 3; c++) begin
      chk("wr_gnt", 64'(gnt_a), 64'(2'b10));
      chk("wr_we", 64'(bwe_a), 64'(1));
      chk("wr_addr", 64'(baddr_a), 64'(32'h2004));
      chk("wr_wdata", 64'(bwdata_a), 64'(32'h1234_5678));
      if (c < 3) begin
        chk("wr_noack", 64'(ack_a), 64'(0));
        tick();
      end else begin
        bus_ack = 1'b1;
        #1;
        sb_check("wr");
      end
    end
    tick();
    bus_ack = 1'b0;
    req     = '0;
    req_we  = '0;
    #1;
    chk("wr_idle_breq", 64'(breq_a), 64'(0));

    // spurious ack while IDLE
    bus_ack = 1'b1;
    #1;
    chk("sp_ack", 64'(ack_a), 64'(0));
    chk("sp_err", 64'(err_a), 64'(0));
    tick();
    chk("sp_breq", 64'(breq_a), 64'(0));
    chk("sp_gnt", 64'(gnt_a), 64'(0));
    chk("sp_ack2", 64'(ack_a), 64'(0));
    bus_ack = 1'b0;

    // reset in the 2nd BUSY cycle abandons the transaction
    req = 2'b01;
    tick();
    chk("mr_breq", 64'(breq_a), 64'(1));
    tick();
    rst = 1'b1;
    #1;
    chk("mr_ack", 64'(ack_a), 64'(0));
    tick();
    rst = 1'b0;
    chk("mr_gnt", 64'(gnt_a), 64'(0));
    chk("mr_breq0", 64'(breq_a), 64'(0));
    chk("mr_ack0", 64'(ack_a), 64'(0));
    req = 2'b11;
    sb.push_back('{2'b01, 2'b00, 32'h77});
    tick();
    chk("mr_first_gnt", 64'(gnt_a), 64'(2'b01));
    bus_ack   = 1'b1;
    bus_rdata = 32'h77;
    #1;
    sb_check("mr");
    tick();
    bus_ack = 1'b0;
    req     = '0;
    #1;

    // timeout after 4 BUSY cycles; the TIMEOUT_CYCLES=0 DUT stays BUSY
    req = 2'b01;
    sb.push_back('{2'b01, 2'b01, 32'h0});
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk("to_breq_z", 64'(breq_z), 64'(1));
      if (c < 4) begin
        chk("to_early_ack", 64'(ack_a), 64'(0));
        chk("to_early_err", 64'(err_a), 64'(0));
        tick();
      end else begin
        sb_check("to");
      end
    end
    tick();
    req = '0;
    #1;
    chk("to_idle_breq", 64'(breq_a), 64'(0));
    chk("to_idle_gnt", 64'(gnt_a), 64'(0));
    for (int j = 0; j < 8; j++) begin
      chk("z_busy_breq", 64'(breq_z), 64'(1));
      chk("z_busy_ack", 64'(ack_z), 64'(0));
      tick();
    end
    bus_ack = 1'b1;
    #1;
    chk("z_ack", 64'(ack_z), 64'(2'b01));
    chk("z_err", 64'(err_z), 64'(0));
    chk("z_a_idle_ack", 64'(ack_a), 64'(0));
    tick();
    bus_ack = 1'b0;
    #1;
    chk("z_idle_breq", 64'(breq_z), 64'(0));

    // real ack on the expiry cycle completes without error
    req = 2'b01;
    sb.push_back('{2'b01, 2'b00, 32'h55});
    tick();
    for (int c = 1; c <= 3; c++) begin
      chk("ex_early_ack", 64'(ack_a), 64'(0));
      tick();
    end
    bus_ack   = 1'b1;
    bus_rdata = 32'h55;
    #1;
    sb_check("ex");
    tick();
    bus_ack = 1'b0;
    req     = '0;
    #1;
    chk("ex_idle_breq", 64'(breq_a), 64'(0));
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
